pmem_burst_responder: RTL

PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

---
 rtl/pmem_burst_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the 4 x 64-bit cacheline burst protocol.
// A request is accepted in IDLE and its index/op latched. After LATENCY wait
// cycles, four beats are transferred with pmem_resp high. One DONE cycle
// follows before the next request can be accepted.
// Storage is split into four 64-bit banks, one per beat position. A read
// copies the whole line into a register at acceptance, and the beats are
// then multiplexed out.
module pmem_burst_responder #(
    parameter int ADDR_BITS = 5,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp
);

    localparam int LINES = 1 << ADDR_BITS;
    // Last value of the wait counter before the burst starts. Unused when LATENCY=0.
    localparam logic [3:0] WAIT_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_wait;
    logic [3:0]             w_wait_next;
    logic [1:0]             r_beat;
    logic [1:0]             w_beat_next;
    logic [ADDR_BITS-1:0]   r_index;
    logic                   r_is_write;

    logic                   w_accept;
    logic                   w_wr_en;
    logic [ADDR_BITS-1:0]   w_index;
    logic [255:0]           w_line;
    logic                   w_unused_addr_bits;

    // Line index from the byte address. The byte offset and the high bits alias.
    assign w_index            = pmem_address[ADDR_BITS+4:5];
    assign w_unused_addr_bits = ^{pmem_address[31:ADDR_BITS+5], pmem_address[4:0]};

    // A request is accepted only from IDLE. DONE and WAIT ignore the request lines.
    assign w_accept = (r_state == S_IDLE) && (pmem_read || pmem_write);

    // Write beats are committed at the clock edge that ends their cycle.
    // A reset at that edge discards the beat.
    assign w_wr_en = (r_state == S_BURST) && r_is_write && !rst;

    // One storage bank per beat position. The line is read out registered at acceptance.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [63:0] r_bank [LINES];
            logic [63:0] r_rd_data;

            // Bank write on this bank's beat, and a registered read when a request is accepted.
            always_ff @(posedge clk) begin
                if (w_wr_en && (r_beat == 2'(gi))) begin
                    r_bank[r_index] <= pmem_wdata;
                end
                if (w_accept) begin
                    r_rd_data <= r_bank[w_index];
                end
            end

            assign w_line[64*gi +: 64] = r_rd_data;
        end
    endgenerate

    // Latch the transaction attributes. Write wins when both requests are high.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_index    <= w_index;
            r_is_write <= pmem_write;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            r_beat  <= w_beat_next;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_beat_next  = r_beat;
        case (r_state)
            S_IDLE: begin
                if (pmem_read || pmem_write) begin
                    w_wait_next  = 4'd0;
                    w_beat_next  = 2'd0;
                    w_state_next = (LATENCY > 0) ? S_WAIT : S_BURST;
                end
            end
            S_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_wait_next  = 4'd0;
                    w_state_next = S_BURST;
                end else begin
                    w_wait_next = r_wait + 4'd1;
                end
            end
            S_BURST: begin
                if (r_beat == 2'd3) begin
                    w_beat_next  = 2'd0;
                    w_state_next = S_DONE;
                end else begin
                    w_beat_next = r_beat + 2'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs. The beat strobe is high throughout BURST. Read data is zero unless a read beat is live.
    always_comb begin
        pmem_resp  = (r_state == S_BURST);
        pmem_rdata = 64'd0;
        if ((r_state == S_BURST) && !r_is_write) begin
            pmem_rdata = w_line[{r_beat, 6'b0} +: 64];
        end
    end

endmodule
